// File: rtl/dircc_gpio_link_rx.sv
// Fabric-side receiver for the HPS GPIO53/54 bit-banged serial link: pin sync, frame decode, word FIFO.
// Optional even-parity bit per frame is enabled by defining DIRCC_GPIO_LINK_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (sample 0 on an sclk rising edge)
// DATA   | shifting WORD_W data bits in, MSB first
// PARITY | waiting for the even-parity bit (parity build only)
module dircc_gpio_link_rx #(
    parameter int WORD_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              gpio_sclk,
    input  logic              gpio_sdata,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overflow,
    output logic              busy
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(WORD_W + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
`ifdef DIRCC_GPIO_LINK_PARITY_EN
    localparam int SHIFT_W = WORD_W;
`else
    localparam int SHIFT_W = WORD_W - 1;
`endif
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WORD_W - 1);
    // Registered frame_err lands TIMEOUT_CYCLES cycles after the last edge cycle.
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA
`ifdef DIRCC_GPIO_LINK_PARITY_EN
        , PARITY
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync;
    logic                   sclk_prev;
    logic                   sclk_edge, sample;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync  <= '1;
            sdata_sync <= '1;
            sclk_prev  <= 1'b1;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], gpio_sclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], gpio_sdata};
            sclk_prev  <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_edge = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sample    = sdata_sync[SYNC_STAGES-1];

    state_t              state;
    logic [SHIFT_W-1:0]  shift_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TMR_W-1:0]    tmr;
    logic                frame_done, frame_good;
    logic [WORD_W-1:0]   frame_word;

    always_comb begin
        frame_done = 1'b0;
        frame_good = 1'b0;
`ifdef DIRCC_GPIO_LINK_PARITY_EN
        frame_word = shift_q;
        if (state == PARITY && sclk_edge) begin
            frame_done = 1'b1;
            frame_good = ~(^{shift_q, sample});
        end
`else
        frame_word = {shift_q, sample};
        if (state == DATA && sclk_edge && bit_cnt == BIT_LAST) begin
            frame_done = 1'b1;
            frame_good = 1'b1;
        end
`endif
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, fifo_count;
    logic              pop, push, can_accept;

    assign fifo_count = wr_ptr - rd_ptr;
    assign rx_valid   = (wr_ptr != rd_ptr);
    assign rx_data    = mem[rd_ptr[ADDR_W-1:0]];
    assign pop        = rx_valid & rx_ready;
    assign can_accept = (fifo_count != DEPTH) | pop;
    assign push       = frame_done & frame_good & can_accept;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            tmr       <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            if (frame_done) begin
                state <= IDLE;
                tmr   <= '0;
                if (!frame_good)
                    frame_err <= 1'b1;
                else if (!can_accept)
                    overflow <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tmr <= '0;
                        if (sclk_edge && !sample) begin
                            shift_q <= '0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    default: begin
                        if (sclk_edge) begin
                            tmr <= '0;
                            if (state == DATA) begin
                                shift_q <= {shift_q[SHIFT_W-2:0], sample};
                                bit_cnt <= bit_cnt + 1'b1;
`ifdef DIRCC_GPIO_LINK_PARITY_EN
                                if (bit_cnt == BIT_LAST)
                                    state <= PARITY;
`endif
                            end
                        end else if (tmr == TMR_LAST) begin
                            state     <= IDLE;
                            tmr       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[ADDR_W-1:0]] <= frame_word;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_dircc_gpio_link_rx.sv
// Scoreboard bench for dircc_gpio_link_rx: expected words queued at send time, checked on handshake.
module tb_dircc_gpio_link_rx;

    localparam int WORD_W         = 32;
    localparam int FIFO_DEPTH     = 4;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int HALF           = 4;
`ifdef DIRCC_GPIO_LINK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk_clk = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic              gpio_sclk = 1'b1;
    logic              gpio_sdata = 1'b1;
    logic              rx_ready = 1'b0;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid, frame_err, overflow, busy;

    int n_checks = 0;
    int n_errs   = 0;
    int n_ferr   = 0;
    int n_ovf    = 0;
    logic [WORD_W-1:0] sb_q[$];

    dircc_gpio_link_rx #(
        .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH),
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .gpio_sclk(gpio_sclk), .gpio_sdata(gpio_sdata),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overflow(overflow), .busy(busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_clk);
        #1;
    endtask

    // Returns just after driving the final sclk rise, so callers can time from the last edge.
    task automatic send_frame(input logic [WORD_W-1:0] w, input int nbits, input bit bad_par);
        bit bits[$];
        repeat (HALF) tick;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++)
            bits.push_back(w[WORD_W-1-i]);
        if (PAR_EN && nbits == WORD_W)
            bits.push_back((^w) ^ bad_par);
        for (int i = 0; i < bits.size(); i++) begin
            gpio_sdata = bits[i];
            gpio_sclk  = 1'b0;
            repeat (HALF) tick;
            gpio_sclk  = 1'b1;
            if (i != bits.size() - 1)
                repeat (HALF) tick;
        end
    endtask

    task automatic watch(input int cycles, output int v_first, output int v_cnt,
                         output int e_first, output int e_cnt);
        v_first = 0; v_cnt = 0; e_first = 0; e_cnt = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
            if (rx_valid) begin
                v_cnt++;
                if (v_first == 0) v_first = k;
            end
            if (frame_err) begin
                e_cnt++;
                if (e_first == 0) e_first = k;
            end
        end
    endtask

    task automatic drain(input string tag);
        rx_ready = 1'b1;
        for (int i = 0; i < 40 && (rx_valid || sb_q.size() != 0); i++)
            tick;
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_sb_left"}, sb_q.size(), 0);
    endtask

    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            if (frame_err) n_ferr++;
            if (overflow)  n_ovf++;
            if (frame_err || overflow)
                chk("pulse_excl", frame_err & overflow, 0);
            if (rx_valid && rx_ready) begin
                if (sb_q.size() == 0)
                    chk("sb_underflow", rx_valid, 0);
                else
                    chk("rx_data", rx_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errs);
        $fatal(1, "watchdog");
    end

    initial begin
        int vf, vc, ef, ec, ferr0, ovf0;

        repeat (3) tick;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        reset_reset_n = 1'b1;
        repeat (4) tick;
        chk("idle_busy", busy, 0);

        // Single good word, consumer always ready
        rx_ready = 1'b1;
        ferr0 = n_ferr; ovf0 = n_ovf;
        sb_q.push_back(32'hDEADBEEF);
        send_frame(32'hDEADBEEF, WORD_W, 1'b0);
        watch(SYNC_STAGES + 6, vf, vc, ef, ec);
        chk("t1_valid_at", vf, SYNC_STAGES + 1);
        chk("t1_valid_len", vc, 1);
        chk("t1_pulses", (n_ferr - ferr0) + (n_ovf - ovf0), 0);
        chk("t1_busy", busy, 0);
        chk("t1_sb_left", sb_q.size(), 0);

`ifdef DIRCC_GPIO_LINK_PARITY_EN
        ferr0 = n_ferr;
        send_frame(32'h00000001, WORD_W, 1'b1);
        watch(SYNC_STAGES + 6, vf, vc, ef, ec);
        chk("t2_ferr_at", ef, SYNC_STAGES + 1);
        chk("t2_ferr_len", ec, 1);
        chk("t2_no_push", vc, 0);
        chk("t2_busy", busy, 0);
        chk("t2_ferr_cnt", n_ferr - ferr0, 1);
`endif

        // Fill FIFO with consumer stalled, fifth word overflows
        rx_ready = 1'b0;
        ferr0 = n_ferr; ovf0 = n_ovf;
        for (int i = 1; i <= 5; i++) begin
            if (i <= FIFO_DEPTH) sb_q.push_back(WORD_W'(i));
            send_frame(WORD_W'(i), WORD_W, 1'b0);
        end
        repeat (SYNC_STAGES + 3) tick;
        chk("t3_ovf_cnt", n_ovf - ovf0, 1);
        chk("t3_ferr_cnt", n_ferr - ferr0, 0);
        chk("t3_valid", rx_valid, 1);
        drain("t3_drain");

        // Full FIFO, pop and push in the same cycle
        rx_ready = 1'b0;
        ovf0 = n_ovf;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            sb_q.push_back(32'hA0 + WORD_W'(i));
            send_frame(32'hA0 + WORD_W'(i), WORD_W, 1'b0);
        end
        repeat (SYNC_STAGES + 3) tick;
        sb_q.push_back(32'h0000_00E5);
        send_frame(32'h0000_00E5, WORD_W, 1'b0);
        tick;
        tick;
        rx_ready = 1'b1;
        tick;
        rx_ready = 1'b0;
        repeat (3) tick;
        chk("t5_ovf_cnt", n_ovf - ovf0, 0);
        chk("t5_one_pop", sb_q.size(), FIFO_DEPTH);
        chk("t5_valid", rx_valid, 1);
        drain("t5_drain");

        // Partial frame then sclk held high: timeout
        rx_ready = 1'b1;
        ferr0 = n_ferr;
        send_frame(32'h5A5A5A5A, 10, 1'b0);
        watch(SYNC_STAGES + TIMEOUT_CYCLES + 4, vf, vc, ef, ec);
        chk("t4_to_at", ef, SYNC_STAGES + TIMEOUT_CYCLES);
        chk("t4_to_len", ec, 1);
        chk("t4_no_push", vc, 0);
        chk("t4_busy", busy, 0);
        sb_q.push_back(32'hCAFEF00D);
        send_frame(32'hCAFEF00D, WORD_W, 1'b0);
        repeat (SYNC_STAGES + 4) tick;
        chk("t4_after_sb", sb_q.size(), 0);
        chk("t4_after_ferr", n_ferr - ferr0, 1);

        // Reset mid-frame with buffered words
        rx_ready = 1'b0;
        sb_q.push_back(32'h11);
        send_frame(32'h11, WORD_W, 1'b0);
        sb_q.push_back(32'h22);
        send_frame(32'h22, WORD_W, 1'b0);
        send_frame(32'hFFFF0000, 16, 1'b0);
        repeat (SYNC_STAGES + 2) tick;
        chk("t6_busy_pre", busy, 1);
        chk("t6_valid_pre", rx_valid, 1);
        reset_reset_n = 1'b0;
        #1;
        chk("t6_valid_rst", rx_valid, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_data_rst", rx_data, 0);
        sb_q.delete();
        repeat (2) tick;
        reset_reset_n = 1'b1;
        tick;
        rx_ready = 1'b1;
        sb_q.push_back(32'h12345678);
        send_frame(32'h12345678, WORD_W, 1'b0);
        repeat (SYNC_STAGES + 4) tick;
        chk("t6_after_sb", sb_q.size(), 0);
        chk("t6_after_valid", rx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
